// File: rtl/uart_cmd_port_if.sv
// Bus bundle of the UART command decoder: UART byte side plus port bank side.
// master = decoder, slave = UART core / port bank.
interface uart_cmd_port_if;
    logic        rxready;
    logic [7:0]  rxdata;
    logic        txready;
    logic        txen;
    logic [7:0]  txdata;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic        busy;
    logic        cmd_err;

    modport master (
        input  rxready, rxdata, txready, rd_data,
        output txen, txdata, wr_en, wr_addr, wr_data,
        output rd_addr, busy, cmd_err
    );

    modport slave (
        output rxready, rxdata, txready, rd_data,
        input  txen, txdata, wr_en, wr_addr, wr_data,
        input  rd_addr, busy, cmd_err
    );
endinterface

// File: rtl/uart_cmd_port.sv
// Host byte-protocol decoder: 0x2p + 4 bytes writes port p, 0x3p reads it back.
// Optional CMD_TIMEOUT_EN aborts a stalled write frame after TIMEOUT_CYCLES.
module uart_cmd_port #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic            clock,
    input  logic            reset_n,
    uart_cmd_port_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        RD_LOAD,
        TX_SEND,
        TX_GAP,
        TX_WAIT
    } state_t;

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES >= (1 << 24)) begin : g_bad_tmo
        $error("TIMEOUT_CYCLES must be in 1 .. 2^24-1");
    end

    state_t      state, state_d;
    logic [1:0]  cnt, cnt_d;
    logic [31:0] shreg, shreg_d;
    logic        wr_en_d;
    logic [3:0]  wr_addr_d;
    logic [31:0] wr_data_d;
    logic [3:0]  rd_addr_d;
    logic        txen_d;
    logic [7:0]  txdata_d;
    logic        cmd_err_d;
    logic        tmo_hit;

`ifdef CMD_TIMEOUT_EN
    localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);

    logic [23:0] tmo;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo <= '0;
        end else if (state != WR_DATA || bus.rxready || tmo_hit) begin
            tmo <= '0;
        end else begin
            tmo <= tmo + 24'd1;
        end
    end

    assign tmo_hit = (state == WR_DATA) && !bus.rxready && (tmo == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            bus.rd_addr <= '0;
            bus.txen    <= 1'b0;
            bus.txdata  <= '0;
            bus.cmd_err <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            shreg       <= shreg_d;
            bus.wr_en   <= wr_en_d;
            bus.wr_addr <= wr_addr_d;
            bus.wr_data <= wr_data_d;
            bus.rd_addr <= rd_addr_d;
            bus.txen    <= txen_d;
            bus.txdata  <= txdata_d;
            bus.cmd_err <= cmd_err_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        shreg_d   = shreg;
        wr_en_d   = 1'b0;
        wr_addr_d = bus.wr_addr;
        wr_data_d = bus.wr_data;
        rd_addr_d = bus.rd_addr;
        txen_d    = 1'b0;
        txdata_d  = bus.txdata;
        cmd_err_d = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.rxready) begin
                    unique case (bus.rxdata[7:4])
                        4'b0010: begin
                            wr_addr_d = bus.rxdata[3:0];
                            cnt_d     = '0;
                            state_d   = WR_DATA;
                        end
                        4'b0011: begin
                            rd_addr_d = bus.rxdata[3:0];
                            state_d   = RD_LOAD;
                        end
                        default: cmd_err_d = 1'b1;
                    endcase
                end
            end
            WR_DATA: begin
                if (bus.rxready) begin
                    shreg_d = {shreg[23:0], bus.rxdata};
                    cnt_d   = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        wr_data_d = {shreg[23:0], bus.rxdata};
                        wr_en_d   = 1'b1;
                        state_d   = IDLE;
                    end
                end else if (tmo_hit) begin
                    cmd_err_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            RD_LOAD: begin
                shreg_d = bus.rd_data;
                cnt_d   = '0;
                state_d = TX_SEND;
            end
            TX_SEND: begin
                if (bus.txready) begin
                    txdata_d = shreg[31:24];
                    txen_d   = 1'b1;
                    shreg_d  = {shreg[23:0], 8'h00};
                    cnt_d    = cnt + 2'd1;
                    state_d  = TX_GAP;
                end
            end
            // UART needs a cycle to drop txready after seeing txen
            TX_GAP: state_d = TX_WAIT;
            TX_WAIT: begin
                if (bus.txready) begin
                    state_d = (cnt == 2'd0) ? IDLE : TX_SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_uart_cmd_port.sv
// Scoreboard bench for uart_cmd_port: directed byte frames, monitor checks
// every wr_en / txen / cmd_err pulse against queued expectations.
module tb_uart_cmd_port;

    localparam int unsigned TMO = 1000;

    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
    } wr_t;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    logic txready_m = 1'b1;
    logic [31:0] port_val [16];
    int tx_busy = 0;

    int checks = 0;
    int errors = 0;
    int tx_seen = 0;
    int pending_err = 0;
    logic prev_txen = 1'b0;
    wr_t exp_wr[$];
    logic [7:0] exp_tx[$];

    always #5 clock = ~clock;

    uart_cmd_port_if bus();

    uart_cmd_port #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.txready = txready_m;
    assign bus.rd_data = port_val[bus.rd_addr];

    // UART transmitter model: busy for 6 cycles after each txen
    always @(posedge clock) begin
        if (!reset_n) begin
            txready_m <= 1'b1;
            tx_busy   <= 0;
        end else if (bus.txen) begin
            txready_m <= 1'b0;
            tx_busy   <= 6;
        end else if (tx_busy > 1) begin
            tx_busy <= tx_busy - 1;
        end else if (tx_busy == 1) begin
            tx_busy   <= 0;
            txready_m <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.wr_en) begin
                chk("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
                if (exp_wr.size() != 0) begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr_data", 64'({bus.wr_addr, bus.wr_data}), 64'(e));
                end
            end
            if (bus.txen) begin
                tx_seen++;
                chk("txen_ready", 64'(txready_m), 64'd1);
                chk("txen_gap", 64'(prev_txen), 64'd0);
                chk("tx_expected", 64'(exp_tx.size() != 0), 64'd1);
                if (exp_tx.size() != 0) begin
                    logic [7:0] b;
                    b = exp_tx.pop_front();
                    chk("tx_byte", 64'(bus.txdata), 64'(b));
                end
            end
            if (bus.cmd_err) begin
                chk("err_expected", 64'(pending_err != 0), 64'd1);
                if (pending_err != 0) pending_err--;
            end
        end
        prev_txen = bus.txen;
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clock);
        #1;
        bus.rxdata  = b;
        bus.rxready = 1'b1;
        @(posedge clock);
        #1;
        bus.rxready = 1'b0;
    endtask

    task automatic push_wr(input logic [3:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_wr.push_back(e);
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_tx.push_back(w[31:24]);
        exp_tx.push_back(w[23:16]);
        exp_tx.push_back(w[15:8]);
        exp_tx.push_back(w[7:0]);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_wr.size() != 0 || exp_tx.size() != 0 ||
                pending_err != 0 || bus.busy) && n < 500) begin
            @(posedge clock);
            n++;
        end
        repeat (4) @(posedge clock);
        chk(name, 64'(n < 500), 64'd1);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctl"},
            64'({bus.txen, bus.wr_en, bus.busy, bus.cmd_err}), 64'd0);
        chk({name, "_data"},
            64'({bus.txdata, bus.wr_addr, bus.wr_data, bus.rd_addr}), 64'd0);
    endtask

    initial begin
        int base;
        int n;
        bus.rxready = 1'b0;
        bus.rxdata  = 8'h00;
        for (int i = 0; i < 16; i++) port_val[i] = 32'h1000_0000 + i;
        port_val[0] = 32'hDEAD_BEEF;
        port_val[1] = 32'h0000_0280;
        port_val[5] = 32'hA1B2_C3D4;

        #1 reset_n = 1'b0;
        #1 chk_zero("reset");
        #10 reset_n = 1'b1;

        // write 0x0000000E to port 2
        send_byte(8'h22);
        chk("busy_wr", 64'(bus.busy), 64'd1);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        push_wr(4'h2, 32'h0000_000E);
        send_byte(8'h0E);
        chk("busy_wr_done", 64'(bus.busy), 64'd0);
        drain("drain_wr1");

        // write -79 to port 3
        send_byte(8'h23);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'hFF);
        push_wr(4'h3, 32'hFFFF_FFB1);
        send_byte(8'hB1);
        drain("drain_wr2");

        // read port 1, with stray bytes during the reply
        push_word(32'h0000_0280);
        send_byte(8'h31);
        chk("rd_addr1", 64'(bus.rd_addr), 64'd1);
        repeat (3) @(posedge clock);
        send_byte(8'h22);
        send_byte(8'h45);
        drain("drain_rd1");

        // bad command, then a read
        pending_err++;
        send_byte(8'h45);
        chk("busy_bad", 64'(bus.busy), 64'd0);
        drain("drain_bad");
        push_word(32'hDEAD_BEEF);
        send_byte(8'h30);
        chk("rd_addr0", 64'(bus.rd_addr), 64'd0);
        drain("drain_rd0");

`ifdef CMD_TIMEOUT_EN
        pending_err++;
        send_byte(8'h26);
        send_byte(8'h12);
        send_byte(8'h34);
        repeat (TMO + 1) @(posedge clock);
        chk("tmo_idle", 64'(bus.busy), 64'd0);
        drain("drain_tmo");
        send_byte(8'h26);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        push_wr(4'h6, 32'h0000_0001);
        send_byte(8'h01);
        drain("drain_tmo_wr");
`else
        send_byte(8'h26);
        send_byte(8'h12);
        send_byte(8'h34);
        repeat (TMO + 1) @(posedge clock);
        chk("notmo_busy", 64'(bus.busy), 64'd1);
        send_byte(8'h56);
        push_wr(4'h6, 32'h1234_5678);
        send_byte(8'h78);
        drain("drain_notmo_wr");
`endif

        // reset in the middle of a reply
        push_word(32'hA1B2_C3D4);
        base = tx_seen;
        send_byte(8'h35);
        n = 0;
        while (tx_seen < base + 2 && n < 300) begin
            @(posedge clock);
            n++;
        end
        chk("rd_two_bytes", 64'(n < 300), 64'd1);
        #2 reset_n = 1'b0;
        #1 chk_zero("midreset");
        exp_tx.delete();
        base = tx_seen;
        #20 reset_n = 1'b1;
        repeat (60) @(posedge clock);
        chk("no_tx_after_reset", 64'(tx_seen), 64'(base));

        push_word(32'h0000_0280);
        send_byte(8'h31);
        drain("drain_rd_after_reset");

        chk("left_wr", 64'(exp_wr.size()), 64'd0);
        chk("left_tx", 64'(exp_tx.size()), 64'd0);
        chk("left_err", 64'(pending_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_port.md
# uart_cmd_port

Command decoder between the board UART core and the user I/O port bank. Parses the host byte protocol: write command 0x2p + 4 data bytes MSB first, read command 0x3p → 4 reply bytes MSB first. Presents writes as a one-cycle strobe to the port register bank. Captures read data from the port input mux and serialises it back through the UART transmitter.

## Interface
- TIMEOUT_CYCLES, 100000: idle clocks allowed between bytes of one write frame before abort (1 ms at 100 MHz); must be < 2^24.
- clock  in  1  master clock, 100 MHz
- reset_n  in  1  asynchronous, active-low reset
- rxready  in  1  one-cycle pulse: rxdata holds a newly received byte
- rxdata  in  8  received byte
- txready  in  1  high when the UART transmitter can accept a byte
- txen  out  1  one-cycle pulse: load txdata and start transmission
- txdata  out  8  byte to transmit
- wr_en  out  1  one-cycle port write strobe
- wr_addr  out  4  port address for write
- wr_data  out  32  port write data
- rd_addr  out  4  port address driven to the input mux
- rd_data  in  32  input port value for rd_addr (combinational from parent)
- busy  out  1  high in any state other than IDLE
- cmd_err  out  1  one-cycle pulse on unrecognised command byte or write timeout

## Operation
- States: IDLE, WR_DATA, RD_LOAD, TX_SEND, TX_GAP, TX_WAIT.
- IDLE, rxready with rxdata[7:4]=4'b0010:
  - wr_addr<=rxdata[3:0], byte count<=0 → WR_DATA.
- IDLE, rxready with rxdata[7:4]=4'b0011:
  - rd_addr<=rxdata[3:0] → RD_LOAD.
- IDLE, any other byte: cmd_err pulse, stay IDLE.
- WR_DATA:
  - Each rxready shifts rxdata into a 32-bit shift register from the LSB side (first byte ends in [31:24]).
  - On the 4th byte: wr_data<=assembled word, wr_en=1 for the next cycle only → IDLE.
- RD_LOAD: latch rd_data into a 32-bit tx shift register, byte count<=0 → TX_SEND.
- TX_SEND: when txready=1, txdata<=shift[31:24], txen=1 for one cycle, shift left 8 → TX_GAP.
- TX_GAP: one cycle; txready ignored (UART drops it after txen) → TX_WAIT.
- TX_WAIT: when txready=1, go to TX_SEND if fewer than 4 bytes sent, else IDLE.
- rxready outside IDLE/WR_DATA: byte discarded silently, no cmd_err.
- wr_addr/wr_data/rd_addr hold their last value until next overwritten.
- Arithmetic: byte count 2 bits, wraps naturally; data is passed raw (signed values are two's complement bit patterns, no extension).

## Timing
- Reset (async, any state, including mid-frame or mid-transmission): state IDLE; txen, wr_en, busy, cmd_err = 0; txdata, wr_addr, wr_data, rd_addr = 0; counters cleared.
  - A partially received write is dropped; a partially sent reply is truncated.
- Write latency: wr_en high exactly one clock, the cycle after the rxready of the 4th data byte; wr_data/wr_addr are stable from that cycle on.
- Read latency:
  - rd_addr is valid the cycle after the command rxready.
  - rd_data is sampled one cycle later (RD_LOAD).
  - First txen no earlier than the following cycle.
- txen is never asserted while txready=0, and never in two consecutive cycles.
- cmd_err is asserted the cycle after the offending rxready, or the cycle after timeout expiry.

## Configuration
- CMD_TIMEOUT_EN defined:
  - In WR_DATA, a 24-bit counter clears on each rxready and increments otherwise.
  - On reaching TIMEOUT_CYCLES: cmd_err pulse, frame discarded, no wr_en → IDLE.
- Undefined:
  - No counter; WR_DATA waits indefinitely for 4 bytes.
  - cmd_err is raised only for bad command bytes.

## Test plan
- Bytes 0x22,00,00,00,0x0E → single wr_en pulse, wr_addr=2, wr_data=0x0000000E; busy high from byte 1 until IDLE.
- Bytes 0x23,FF,FF,FF,B1 (write −79 to port 3) → wr_data=0xFFFFFFB1, wr_addr=3, one wr_en.
- Byte 0x31 with rd_data=0x00000280:
  - rd_addr=1.
  - Transmitted bytes 00,00,02,80 in order.
  - Exactly 4 txen pulses, each only while txready=1; extra rx bytes during reply are ignored.
- Byte 0x45 → cmd_err one cycle, state stays IDLE.
  - A following 0x30 read proceeds normally.
- CMD_TIMEOUT_EN, TIMEOUT_CYCLES=1000: bytes 0x26,12,34 then 1001 idle clocks → cmd_err pulse, no wr_en.
  - Subsequent 0x26,00,00,00,01 → wr_data=0x00000001.
- Assert reset_n=0 after the 2nd reply byte of a read:
  - All outputs zero immediately.
  - After release, no further txen until a new command arrives.
